drive_mode_arbiter: RTL and testbench
=====================================

Name: drive_mode_arbiter

Overview:
- Owns car power sequencing and shares the single motion-output resource between three driving-mode controllers: manual, semi-auto and auto.
- Grants exactly one mode at a time and enforces a stopped drain interval on every mode change.
- Sanitises conflicting motion bits and registers the final 4-bit motion vector that drives the lights/motor outputs.
- Sits between the mode controllers and the top-level output pins.

Parameters:
- PWR_HOLD, 100000000, cycles power_btn must be held continuously to toggle power (1 s at 100 MHz).
- DRAIN_CYC, 50000000, cycles of forced stop on a mode change.
- WDT_CYC, 10000000, watchdog limit for invalid semi/auto commands; used only with the optional feature.
- CNT_W, 27, counter width; must satisfy 2^CNT_W > max(PWR_HOLD, DRAIN_CYC, WDT_CYC).

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-low reset
- power_btn  in  1  power button, synchronised upstream
- mode_sel  in  2  00 manual, 01 semi, 10 auto, 11 reserved
- cmd_man  in  4  manual motion command
- cmd_semi  in  4  semi-auto motion command
- cmd_auto  in  4  auto motion command
- vld_semi  in  1  cmd_semi is valid
- vld_auto  in  1  cmd_auto is valid
- off_req  in  3  power-off request pulses, one per mode; bit0 manual, bit1 semi, bit2 auto
- motion  out  4  bit3 right, bit2 left, bit1 back, bit0 forward
- grant  out  3  one-hot active mode, same bit order as off_req
- power_on  out  1  1 while powered
- busy  out  1  1 while in S_DRAIN
- mode_err  out  1  1 while mode_sel==11 blocks a grant
- wdt_fault  out  1  watchdog trip flag; tied 0 when the optional feature is disabled

Behaviour:
- Reset (rst=0, asynchronous): state S_OFF, motion=0000, grant=000, power_on=0, busy=0, mode_err=0, wdt_fault=0, active_mode=00, all counters 0, hold detector disarmed.
- Hold detector:
  - Counts consecutive cycles with power_btn=1 and emits a 1-cycle hold pulse when the count reaches PWR_HOLD.
  - It then stays disarmed until power_btn=0 for at least 1 cycle, so one long press produces exactly one toggle.
- States: S_OFF, S_DRAIN, S_RUN.
- S_OFF:
  - Outputs are zero.
  - On a hold pulse: power_on=1, latch mode_sel, go to S_DRAIN. Power-up always drains first.
- S_DRAIN:
  - grant=000, motion=0000, busy=1, drain counter increments.
  - When the counter reaches DRAIN_CYC-1 and the latched mode is valid: active_mode<=latched mode, grant set, counter cleared, go to S_RUN.
  - If mode_sel==11: mode_err=1 and the counter is held at 0. Re-latch when mode_sel becomes valid.
- S_RUN:
  - motion is registered from the granted command; one cycle latency.
  - Semi/auto: motion=0000 in any cycle where the corresponding vld is 0.
  - mode_sel != active_mode for 1 sampled cycle: clear grant and motion next cycle, latch mode_sel, go to S_DRAIN.
- Sanitising, applied in S_RUN only:
  - bit3&bit2 both 1: clear both.
  - bit1&bit0 both 1: clear both.
  - Example: 1111 gives 0000; 0111 gives 0100.
- Power-off, from S_DRAIN or S_RUN:
  - Causes: a hold pulse, or an off_req bit matching the current grant.
  - Next cycle: S_OFF, all outputs 0, counters cleared.
  - off_req bits for non-granted modes, and any off_req in S_DRAIN, are ignored.
- Priority within one cycle: reset > power-off > watchdog > mode change > normal run.
- Mode change during S_DRAIN: re-latch the new mode and restart the counter at 0.
- A mode_sel change back to active_mode after leaving S_RUN does not cancel the drain.

Optional Feature:
- Macro DRIVE_ARB_WDT_EN.
- Defined:
  - In S_RUN with semi or auto granted, count consecutive cycles with vld=0; reset the count on vld=1.
  - At WDT_CYC: wdt_fault=1 and go to S_OFF, the same as power-off.
  - wdt_fault stays set until the next power-on hold pulse clears it.
- Undefined: no watchdog counter is built, wdt_fault is constant 0, and invalid commands only yield motion=0000.

Decomposition:
- Package drive_arb_pkg holds:
  - mode encodings MODE_MAN/MODE_SEMI/MODE_AUTO/MODE_RSVD
  - motion bit indices MOT_R/MOT_L/MOT_B/MOT_F
  - state encodings S_OFF/S_DRAIN/S_RUN
- One sub-module, btn_hold_det: the hold counter with release re-arm, parameterised by PWR_HOLD and CNT_W.

Test Plan (simulation parameters: PWR_HOLD=4, DRAIN_CYC=3, WDT_CYC=5):
- Hold power_btn 4 cycles with mode_sel=00 → power_on=1; busy=1 for 3 cycles; then grant=001; cmd_man=0001 gives motion=0001 one cycle later.
- Keep power_btn held 10 more cycles after power-on → no second toggle; release, then hold 4 cycles → S_OFF, all outputs 0.
- In S_RUN manual, set mode_sel=10 with vld_auto=1 and cmd_auto=0110 → grant=000 and motion=0000 for 3 cycles, then grant=100, motion=0110.
- mode_sel=11 during drain → mode_err=1 and grant stays 000 indefinitely; mode_sel=01 → drain restarts, then grant=010.
- Granted manual: cmd_man=1111 → motion=0000; 1011 → 1000. off_req=010 → ignored; off_req=001 → power_on=0 next cycle.
- With DRIVE_ARB_WDT_EN, auto granted and vld_auto=0 for 5 cycles → wdt_fault=1 and power_on=0; next power-on hold clears wdt_fault.

Source files
------------

// File: rtl/drive_arb_pkg.sv
// Shared encodings for the drive-mode arbiter: mode codes, motion bit
// positions, FSM states and small helpers for grant and motion clean-up.
package drive_arb_pkg;

    localparam logic [1:0] MODE_MAN  = 2'b00;
    localparam logic [1:0] MODE_SEMI = 2'b01;
    localparam logic [1:0] MODE_AUTO = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam int MOT_R = 3;
    localparam int MOT_L = 2;
    localparam int MOT_B = 1;
    localparam int MOT_F = 0;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_DRAIN = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // One-hot grant for a mode; reserved maps to no grant.
    function automatic logic [2:0] grant_of(input logic [1:0] mode);
        logic [2:0] g;
        case (mode)
            MODE_MAN:  g = 3'b001;
            MODE_SEMI: g = 3'b010;
            MODE_AUTO: g = 3'b100;
            default:   g = 3'b000;
        endcase
        return g;
    endfunction

    // Opposing directions cancel each other rather than picking a winner.
    function automatic logic [3:0] sanitize(input logic [3:0] m);
        logic [3:0] r;
        r = m;
        if (m[MOT_R] && m[MOT_L]) begin
            r[MOT_R] = 1'b0;
            r[MOT_L] = 1'b0;
        end
        if (m[MOT_B] && m[MOT_F]) begin
            r[MOT_B] = 1'b0;
            r[MOT_F] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_hold_det.sv
// Long-press detector: one-cycle pulse on the PWR_HOLD-th consecutive high
// cycle, then disarmed until the button has been seen released.
module btn_hold_det #(
    parameter int PWR_HOLD = 100000000,
    parameter int CNT_W    = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic hold
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PWR_HOLD - 1);

    logic [CNT_W-1:0] cnt;
    logic             armed;

    assign hold = armed && btn && (cnt == HOLD_LAST);

    // Press-length counter; a release both clears it and re-arms the detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (!btn) begin
            cnt   <= '0;
            armed <= 1'b1;
        end else if (hold) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (armed) begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/drive_mode_arbiter.sv
// Power sequencing and motion-output arbitration between the manual,
// semi-auto and auto mode controllers. Every grant is preceded by a forced
// stop (drain) interval. Optional command watchdog: DRIVE_ARB_WDT_EN.
//
// state   | meaning
// S_OFF   | unpowered, all outputs zero, waiting for a long press
// S_DRAIN | powered, motion forced stop, counting down before a grant
// S_RUN   | one mode granted, its sanitised command drives motion
module drive_mode_arbiter
    import drive_arb_pkg::*;
#(
    parameter int PWR_HOLD  = 100000000,
    parameter int DRAIN_CYC = 50000000,
    parameter int WDT_CYC   = 10000000,
    parameter int CNT_W     = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_btn,
    input  logic [1:0] mode_sel,
    input  logic [3:0] cmd_man,
    input  logic [3:0] cmd_semi,
    input  logic [3:0] cmd_auto,
    input  logic       vld_semi,
    input  logic       vld_auto,
    input  logic [2:0] off_req,
    output logic [3:0] motion,
    output logic [2:0] grant,
    output logic       power_on,
    output logic       busy,
    output logic       mode_err,
    output logic       wdt_fault
);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    state_t           state, state_n;
    logic [1:0]       latched, latched_n;
    logic [1:0]       active, active_n;
    logic [CNT_W-1:0] drain_cnt, drain_cnt_n;
    logic [2:0]       grant_n;
    logic [3:0]       motion_n;
    logic             power_on_n, busy_n, mode_err_n;
    logic             hold, off_hit, wdt_trip;
    logic [3:0]       cmd_sel;

    btn_hold_det #(
        .PWR_HOLD (PWR_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .btn  (power_btn),
        .hold (hold)
    );

    // Off request only counts when it comes from the mode holding the grant.
    assign off_hit = |(off_req & grant);

    // Command of the active mode; an invalid semi/auto command means stop.
    always_comb begin
        cmd_sel = 4'b0000;
        case (active)
            MODE_MAN:  cmd_sel = cmd_man;
            MODE_SEMI: cmd_sel = vld_semi ? cmd_semi : 4'b0000;
            MODE_AUTO: cmd_sel = vld_auto ? cmd_auto : 4'b0000;
            default:   cmd_sel = 4'b0000;
        endcase
    end

`ifdef DRIVE_ARB_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYC - 1);

    logic [CNT_W-1:0] wdt_cnt, wdt_cnt_n;
    logic             wdt_fault_q, wdt_fault_n;
    logic             cmd_idle;

    assign cmd_idle  = ((active == MODE_SEMI) && !vld_semi) ||
                       ((active == MODE_AUTO) && !vld_auto);
    assign wdt_trip  = (state == S_RUN) && cmd_idle && (wdt_cnt == WDT_LAST);
    assign wdt_fault = wdt_fault_q;

    // Run of consecutive invalid commands; cleared whenever we leave S_RUN.
    always_comb begin
        wdt_cnt_n = '0;
        if ((state == S_RUN) && (state_n == S_RUN) && cmd_idle)
            wdt_cnt_n = wdt_cnt + CNT_W'(1);
    end

    // Watchdog count and sticky fault flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt     <= '0;
            wdt_fault_q <= 1'b0;
        end else begin
            wdt_cnt     <= wdt_cnt_n;
            wdt_fault_q <= wdt_fault_n;
        end
    end
`else
    assign wdt_trip  = 1'b0;
    assign wdt_fault = 1'b0;
`endif

    // Next-state and next-output decode; priority power-off > watchdog > mode change.
    always_comb begin
        state_n     = state;
        latched_n   = latched;
        active_n    = active;
        drain_cnt_n = drain_cnt;
        grant_n     = grant;
        motion_n    = 4'b0000;
`ifdef DRIVE_ARB_WDT_EN
        wdt_fault_n = wdt_fault_q;
`endif
        case (state)
            S_OFF: begin
                if (hold) begin
                    state_n     = S_DRAIN;
                    latched_n   = mode_sel;
                    drain_cnt_n = '0;
`ifdef DRIVE_ARB_WDT_EN
                    wdt_fault_n = 1'b0;
`endif
                end
            end
            S_DRAIN: begin
                grant_n = 3'b000;
                if (hold) begin
                    state_n = S_OFF;
                end else if (mode_sel != latched) begin
                    latched_n   = mode_sel;
                    drain_cnt_n = '0;
                end else if (mode_sel == MODE_RSVD) begin
                    drain_cnt_n = '0;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_n     = S_RUN;
                    active_n    = latched;
                    grant_n     = grant_of(latched);
                    drain_cnt_n = '0;
                end else begin
                    drain_cnt_n = drain_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (hold || off_hit) begin
                    state_n = S_OFF;
                end else if (wdt_trip) begin
                    state_n = S_OFF;
`ifdef DRIVE_ARB_WDT_EN
                    wdt_fault_n = 1'b1;
`endif
                end else if (mode_sel != active) begin
                    state_n     = S_DRAIN;
                    latched_n   = mode_sel;
                    drain_cnt_n = '0;
                    grant_n     = 3'b000;
                end else begin
                    motion_n = sanitize(cmd_sel);
                end
            end
            default: state_n = S_OFF;
        endcase

        if (state_n == S_OFF) begin
            latched_n   = 2'b00;
            active_n    = 2'b00;
            drain_cnt_n = '0;
            grant_n     = 3'b000;
        end

        power_on_n = (state_n != S_OFF);
        busy_n     = (state_n == S_DRAIN);
        mode_err_n = busy_n && (mode_sel == MODE_RSVD);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_OFF;
            latched   <= 2'b00;
            active    <= 2'b00;
            drain_cnt <= '0;
            grant     <= 3'b000;
            motion    <= 4'b0000;
            power_on  <= 1'b0;
            busy      <= 1'b0;
            mode_err  <= 1'b0;
        end else begin
            state     <= state_n;
            latched   <= latched_n;
            active    <= active_n;
            drain_cnt <= drain_cnt_n;
            grant     <= grant_n;
            motion    <= motion_n;
            power_on  <= power_on_n;
            busy      <= busy_n;
            mode_err  <= mode_err_n;
        end
    end

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Scoreboard bench for drive_mode_arbiter: directed scenarios followed by
// random traffic, checked every cycle against a behavioural model.
module tb_drive_mode_arbiter;

    localparam int PWR_HOLD  = 4;
    localparam int DRAIN_CYC = 3;
    localparam int WDT_CYC   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       power_btn = 1'b0;
    logic [1:0] mode_sel = 2'b00;
    logic [3:0] cmd_man = 4'h0, cmd_semi = 4'h0, cmd_auto = 4'h0;
    logic       vld_semi = 1'b0, vld_auto = 1'b0;
    logic [2:0] off_req = 3'b000;
    logic [3:0] motion;
    logic [2:0] grant;
    logic       power_on, busy, mode_err, wdt_fault;

    drive_mode_arbiter #(
        .PWR_HOLD  (PWR_HOLD),
        .DRAIN_CYC (DRAIN_CYC),
        .WDT_CYC   (WDT_CYC),
        .CNT_W     (27)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .power_btn (power_btn),
        .mode_sel  (mode_sel),
        .cmd_man   (cmd_man),
        .cmd_semi  (cmd_semi),
        .cmd_auto  (cmd_auto),
        .vld_semi  (vld_semi),
        .vld_auto  (vld_auto),
        .off_req   (off_req),
        .motion    (motion),
        .grant     (grant),
        .power_on  (power_on),
        .busy      (busy),
        .mode_err  (mode_err),
        .wdt_fault (wdt_fault)
    );

    always #5 clk = ~clk;

    // directed/random input values applied on the next tick
    logic       d_rst = 1'b0, d_btn = 1'b0, d_vs = 1'b0, d_va = 1'b0;
    logic [1:0] d_sel = 2'b00;
    logic [3:0] d_cm = 4'h0, d_cs = 4'h0, d_ca = 4'h0;
    logic [2:0] d_off = 3'b000;

    // behavioural model: powered / draining flags, drain cycles left
    bit         m_pwr, m_drain, m_fault, m_seen_low;
    int         m_press, m_left, m_idle;
    logic [1:0] m_pend, m_act;
    logic [3:0] m_mot;

    typedef struct {
        logic [11:0] val;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc_no = 0;
    bit stim_done = 1'b0;

    function automatic logic [3:0] clean(input logic [3:0] m);
        logic [3:0] r;
        r = m;
        if ((m & 4'b1100) == 4'b1100) r = r & 4'b0011;
        if ((m & 4'b0011) == 4'b0011) r = r & 4'b1100;
        return r;
    endfunction

    function automatic logic [11:0] model_out();
        logic [2:0] g;
        g = (m_pwr && !m_drain) ? (3'b001 << m_act) : 3'b000;
        return {m_pwr, m_pwr && m_drain, m_drain && (m_pend == 2'b11),
                m_fault, g, m_mot};
    endfunction

    task automatic power_down();
        m_pwr   = 1'b0;
        m_drain = 1'b0;
        m_pend  = 2'b00;
        m_act   = 2'b00;
    endtask

    task automatic start_drain(input logic [1:0] s);
        m_drain = 1'b1;
        m_pend  = s;
        m_left  = DRAIN_CYC;
    endtask

    task automatic model_step();
        bit         hold;
        bit         idle;
        logic [3:0] pick;
        if (!d_rst) begin
            power_down();
            m_fault = 1'b0; m_seen_low = 1'b0; m_press = 0; m_idle = 0;
            m_mot = 4'b0000;
            return;
        end
        if (d_btn) m_press++;
        else begin
            m_press = 0;
            m_seen_low = 1'b1;
        end
        hold  = d_btn && m_seen_low && (m_press == PWR_HOLD);
        m_mot = 4'b0000;
        if (!m_pwr) begin
            if (hold) begin
                m_pwr = 1'b1;
                m_fault = 1'b0;
                start_drain(d_sel);
            end
        end else if (m_drain) begin
            if (hold) power_down();
            else if (d_sel != m_pend || d_sel == 2'b11) start_drain(d_sel);
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_drain = 1'b0;
                    m_act   = m_pend;
                    m_idle  = 0;
                end
            end
        end else begin
            idle   = (m_act == 2'b01 && !d_vs) || (m_act == 2'b10 && !d_va);
            m_idle = idle ? m_idle + 1 : 0;
            if (hold || d_off[int'(m_act)]) power_down();
`ifdef DRIVE_ARB_WDT_EN
            else if (m_idle >= WDT_CYC) begin
                power_down();
                m_fault = 1'b1;
            end
`endif
            else if (d_sel != m_act) start_drain(d_sel);
            else begin
                if (m_act == 2'b00) pick = d_cm;
                else if (m_act == 2'b01) pick = d_vs ? d_cs : 4'b0000;
                else pick = d_va ? d_ca : 4'b0000;
                m_mot = clean(pick);
            end
        end
    endtask

    task automatic tick(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = d_rst; power_btn = d_btn; mode_sel = d_sel;
            cmd_man = d_cm; cmd_semi = d_cs; cmd_auto = d_ca;
            vld_semi = d_vs; vld_auto = d_va; off_req = d_off;
            model_step();
            cyc_no++;
            e.val = model_out();
            e.cyc = cyc_no;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: the DUT presents a fresh output vector every cycle.
    initial begin
        exp_t        e;
        logic [11:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {power_on, busy, mode_err, wdt_fault, grant, motion};
                checks++;
                if (got !== e.val) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got pwr/busy/err/wdt=%b grant=%b motion=%b required pwr/busy/err/wdt=%b grant=%b motion=%b",
                             e.cyc, got[11:8], got[6:4], got[3:0],
                             e.val[11:8], e.val[6:4], e.val[3:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int press_left;
        int starve_left;
        exp_t e0;
        model_step();
        e0.val = model_out();
        e0.cyc = 0;
        exp_q.push_back(e0);

        tick(3);
        d_rst = 1'b1;
        tick(2);

        // power-up in manual, button held well past the toggle
        d_cm = 4'b0001; d_btn = 1'b1;
        tick(14);
        d_btn = 1'b0;
        tick(2);
        d_cm = 4'b1111; tick(2);
        d_cm = 4'b1011; tick(2);
        d_cm = 4'b0111; tick(1);
        d_off = 3'b010; tick(1);
        d_off = 3'b000; tick(1);

        // manual -> auto with a valid command
        d_sel = 2'b10; d_va = 1'b1; d_ca = 4'b0110;
        tick(6);

        // reserved mode blocks the grant, then semi
        d_sel = 2'b11; tick(8);
        d_sel = 2'b01; d_vs = 1'b1; d_cs = 4'b1001; tick(6);
        d_vs = 1'b0; tick(2);
        d_vs = 1'b1; tick(1);

        // back to manual, then off request from manual
        d_sel = 2'b00; tick(5);
        d_off = 3'b100; tick(1);
        d_off = 3'b001; tick(1);
        d_off = 3'b000; tick(2);

        // power on, release, then long press powers off
        d_btn = 1'b1; tick(4);
        d_btn = 1'b0; tick(5);
        d_btn = 1'b1; tick(4);
        d_btn = 1'b0; tick(3);

        // auto granted then starved of valid commands
        d_sel = 2'b10; d_va = 1'b1;
        d_btn = 1'b1; tick(4);
        d_btn = 1'b0; tick(5);
        d_va = 1'b0; tick(8);
        d_btn = 1'b1; tick(4);
        d_btn = 1'b0; tick(3);

        // brief excursion away from the active mode still forces a full drain
        d_sel = 2'b00; d_va = 1'b1;
        d_btn = 1'b1; tick(4);
        d_btn = 1'b0; tick(5);
        d_sel = 2'b01; tick(1);
        d_sel = 2'b00; tick(6);

        // random traffic
        press_left = 0;
        starve_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (press_left == 0 && $urandom_range(0, 39) == 0)
                press_left = $urandom_range(1, 7);
            d_btn = (press_left > 0);
            if (press_left > 0) press_left--;
            if ($urandom_range(0, 29) == 0) d_sel = 2'($urandom_range(0, 3));
            d_cm = 4'($urandom);
            d_cs = 4'($urandom);
            d_ca = 4'($urandom);
            if (starve_left == 0 && $urandom_range(0, 59) == 0)
                starve_left = $urandom_range(2, 8);
            if (starve_left > 0) begin
                d_vs = 1'b0;
                d_va = 1'b0;
                starve_left--;
            end else begin
                d_vs = ($urandom_range(0, 7) != 0);
                d_va = ($urandom_range(0, 7) != 0);
            end
            d_off = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            tick(1);
        end
        stim_done = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_queue left=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
